seg7_multi_display: RTL and testbench

//  Parametrised multi-digit 7-segment driver for the board HEX displays (static, active-low).

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_glyph.sv | 20 ++
 rtl/seg7_multi_display.sv | 142 ++++++++++++++
 tb/tb_seg7_multi_display.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, glyph table and BCD helper for the multi-digit 7-segment driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } seg7_state_t;

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;
  localparam logic [6:0] SEG7_DASH  = 7'b0111111;

  // gfedcba, active low, indexed by nibble value 0..F
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [3:0] dabble_digit(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder with a forced-blank input.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] glyph
);

  // Select blank or table glyph
  always_comb begin
    glyph = SEG7_BLANK;
    if (blank) begin
      glyph = SEG7_BLANK;
    end else begin
      glyph = SEG7_GLYPH[nibble];
    end
  end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment driver: captures a value on start, converts it serially to BCD
// (or splits into nibbles in hex mode) and drives registered active-low glyphs.
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_DIGITS = 6,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  input  logic                    hex_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segments
);

  localparam int BCDW = 4 * NUM_DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);

  seg7_state_t             state_r;
  logic [WIDTH-1:0]        shift_r;
  logic [BCDW-1:0]         bcd_r;
  logic [CW-1:0]           cnt_r;
  logic                    hex_r;
  logic                    ovf_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    overflow_r;
  logic [7*NUM_DIGITS-1:0] segments_r;

  logic [BCDW-1:0]         adj_s;
  logic [BCDW-1:0]         bcd_next_s;
  logic                    carry_s;
  logic [WIDTH+BCDW-1:0]   wide_s;
  logic [BCDW-1:0]         disp_s;
  logic                    ovf_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [6:0]              glyph_s [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_next_s;

  // One double-dabble step: add 3 to digits >= 5, then shift in the value MSB
  always_comb begin
    adj_s = bcd_r;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      adj_s[4*k +: 4] = dabble_digit(bcd_r[4*k +: 4]);
    end
    carry_s    = adj_s[BCDW-1];
    bcd_next_s = {adj_s[BCDW-2:0], shift_r[WIDTH-1]};
  end

  // Digit source, overflow and leading-zero blanking for the pending display update
  always_comb begin : blank_logic
    logic seen_v;
    seen_v  = 1'b0;
    wide_s  = {{BCDW{1'b0}}, shift_r};
    disp_s  = hex_r ? wide_s[BCDW-1:0] : bcd_r;
    ovf_s   = hex_r ? (wide_s[WIDTH+BCDW-1:BCDW] != '0) : ovf_r;
    blank_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      blank_s[k] = ((BLANK_LZ != 0) && !seen_v && (disp_s[4*k +: 4] == 4'd0) && (k != 0))
                 || (!hex_r && (disp_s[4*k +: 4] > 4'd9));
      seen_v     = seen_v | (disp_s[4*k +: 4] != 4'd0);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph u_glyph (
      .nibble (disp_s[4*g +: 4]),
      .blank  (blank_s[g]),
      .glyph  (glyph_s[g])
    );
  end

  // Pack glyphs, replacing every digit with a dash on overflow
  always_comb begin
    seg_next_s = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_next_s[7*k +: 7] = ovf_s ? SEG7_DASH : glyph_s[k];
    end
  end

  // Control FSM with conversion datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bcd_r      <= '0;
      cnt_r      <= '0;
      hex_r      <= 1'b0;
      ovf_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      segments_r <= '1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            shift_r <= value;
            hex_r   <= hex_mode;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= hex_mode ? UPDATE : CONVERT;
          end
        end
        CONVERT: begin
          bcd_r   <= bcd_next_s;
          ovf_r   <= ovf_r | carry_s;
          shift_r <= {shift_r[WIDTH-2:0], 1'b0};
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= UPDATE;
          end
        end
        UPDATE: begin
          segments_r <= seg_next_s;
          overflow_r <= ovf_s;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;
  assign segments = segments_r;

endmodule

// File: tb/tb_seg7_multi_display.sv
// Scoreboard bench: two instances (6 and 4 digits) share stimulus; a decimal/hex
// arithmetic model predicts glyphs, overflow and done timing.
module tb_seg7_multi_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        hex_mode = 1'b0;
  logic [15:0] value = 16'd0;
  logic        busy, done, overflow;
  logic [41:0] segments;
  logic        busy4, done4, overflow4;
  logic [27:0] segments4;

  always #5 clk = ~clk;

  seg7_multi_display #(.WIDTH(16), .NUM_DIGITS(6), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .hex_mode(hex_mode),
    .busy(busy), .done(done), .overflow(overflow), .segments(segments)
  );

  seg7_multi_display #(.WIDTH(16), .NUM_DIGITS(4), .BLANK_LZ(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .value(value), .hex_mode(hex_mode),
    .busy(busy4), .done(done4), .overflow(overflow4), .segments(segments4)
  );

  typedef struct {
    int unsigned cyc;
    logic [41:0] s6;
    logic        o6;
    logic [27:0] s4;
    logic        o4;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned busy_until = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [41:0] cur6;
  logic [27:0] cur4;
  logic        cur_o6, cur_o4;

  logic [6:0] gtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Digits by repeated division; overflow when value >= base**nd
  function automatic void model(input int unsigned v, input bit h, input int nd,
                                output logic [55:0] seg, output logic ovf);
    longint base = h ? 64'd16 : 64'd10;
    longint p = 1;
    int d[8];
    int msd = 0;
    for (int k = 0; k < nd; k++) begin
      d[k] = int'((longint'(v) / p) % base);
      p = p * base;
      if (d[k] != 0) msd = k;
    end
    ovf = (longint'(v) >= p);
    seg = '1;
    for (int k = 0; k < nd; k++) begin
      if (ovf) seg[7*k +: 7] = 7'b0111111;
      else if (k > msd) seg[7*k +: 7] = 7'b1111111;
      else seg[7*k +: 7] = gtab[d[k]];
    end
  endfunction

  task automatic drive(input bit s, input logic [15:0] v, input bit h);
    exp_t e;
    bit acc;
    logic [55:0] m;
    @(negedge clk);
    start = s; value = v; hex_mode = h;
    acc = s && (cyc >= busy_until);
    if (acc) begin
      e.cyc = cyc + 1 + (h ? 1 : 17);
      model(v, h, 6, m, e.o6); e.s6 = m[41:0];
      model(v, h, 4, m, e.o4); e.s4 = m[27:0];
      busy_until = e.cyc;
    end
    @(posedge clk);
    if (acc) q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) drive(1'b0, 16'($urandom), 1'($urandom));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy_until = cyc;
  endtask

  // Monitor: reset values, done-time scoreboard pops, and hold checks between updates
  initial begin
    cur6 = '1; cur4 = '1; cur_o6 = 1'b0; cur_o4 = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        check("rst_seg6", segments, {42{1'b1}});
        check("rst_seg4", segments4, {28{1'b1}});
        check("rst_busy", {busy, busy4}, 2'b00);
        check("rst_done", {done, done4}, 2'b00);
        check("rst_ovf", {overflow, overflow4}, 2'b00);
        cur6 = '1; cur4 = '1; cur_o6 = 1'b0; cur_o4 = 1'b0;
        q.delete();
      end else begin
        check("done4_sync", done4, done);
        if (done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("seg6", segments, e.s6);
            check("ovf6", overflow, e.o6);
            check("seg4", segments4, e.s4);
            check("ovf4", overflow4, e.o4);
            check("busy_at_done", busy, 1'b0);
            cur6 = e.s6; cur4 = e.s4; cur_o6 = e.o6; cur_o4 = e.o4;
          end
        end else begin
          check("hold_seg6", segments, cur6);
          check("hold_seg4", segments4, cur4);
          check("hold_ovf", {overflow, overflow4}, {cur_o6, cur_o4});
          check("busy", busy, q.size() != 0);
          if (q.size() != 0 && q[0].cyc < cyc) begin
            check("missing_done", 1'b0, 1'b1);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy_until = cyc;

    drive(1'b1, 16'd1234, 1'b0);   wait_idle();
    drive(1'b1, 16'hBEEF, 1'b1);   wait_idle();
    drive(1'b1, 16'd0, 1'b0);      wait_idle();
    drive(1'b1, 16'd65535, 1'b0);  wait_idle();
    drive(1'b1, 16'd0, 1'b1);      wait_idle();
    drive(1'b1, 16'd65535, 1'b1);  wait_idle();
    drive(1'b1, 16'd9999, 1'b0);   wait_idle();
    drive(1'b1, 16'd10000, 1'b0);  wait_idle();

    // start during conversion is ignored
    drive(1'b1, 16'd4321, 1'b0);
    drive(1'b0, 16'd1, 1'b1);
    drive(1'b0, 16'd2, 1'b1);
    drive(1'b1, 16'd999, 1'b1);
    wait_idle();

    // reset aborts a conversion, then a fresh one completes
    drive(1'b1, 16'd777, 1'b0);
    repeat (4) drive(1'b0, 16'd3, 1'b0);
    reset_pulse();
    drive(1'b1, 16'd555, 1'b0);    wait_idle();

    // start held through the done cycle is accepted back-to-back
    drive(1'b1, 16'd100, 1'b0);
    repeat (20) drive(1'b1, 16'd42, 1'b0);
    drive(1'b0, 16'd0, 1'b0);
    wait_idle();

    // randomized traffic with occasional resets
    repeat (600) begin
      if ($urandom_range(0, 149) == 0) reset_pulse();
      else drive($urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom));
    end
    drive(1'b0, 16'd0, 1'b0);
    wait_idle();
    repeat (3) drive(1'b0, 16'd0, 1'b0);
    if (q.size() != 0) check("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
